// File: rtl/imem_loader.sv
// Boot loader: frames a byte stream (count, payload, XOR checksum) into big-endian
// 32-bit words for the instruction memory and holds the core in reset until verified.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [31:0]           o_imem_wdata,
  output logic                  o_cpu_reset,
  output logic                  o_done,
  output logic                  o_error,
  output logic [15:0]           o_words_loaded
);

  typedef enum logic [2:0] {
    S_HDR_HI, S_HDR_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] MAX_N = 17'(1) << ADDR_WIDTH;

  state_t                r_state;
  logic [15:0]           r_n;
  logic [23:0]           r_shift;
  logic [1:0]            r_bcnt;
  logic [7:0]            r_acc;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [15:0]           r_words;
  logic                  r_ready;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_error;

  logic        w_take;
  logic [15:0] w_n_full;

  assign w_take   = i_rx_valid && r_ready;
  assign w_n_full = {r_n[15:8], i_rx_data};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_HDR_HI;
      r_n         <= '0;
      r_shift     <= '0;
      r_bcnt      <= '0;
      r_acc       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_words     <= '0;
      r_ready     <= 1'b1;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_HDR_HI: if (w_take) begin
          r_n[15:8] <= i_rx_data;
          r_state   <= S_HDR_LO;
        end
        S_HDR_LO: if (w_take) begin
          r_n[7:0] <= i_rx_data;
          if ({1'b0, w_n_full} > MAX_N) begin
            r_state <= S_ERROR;
            r_ready <= 1'b0;
            r_error <= 1'b1;
          end else if (w_n_full == 16'd0) begin
            r_state <= S_CHECK;
          end else begin
            r_state <= S_DATA;
          end
        end
        S_DATA: if (w_take) begin
          r_acc   <= r_acc ^ i_rx_data;
          r_bcnt  <= r_bcnt + 2'd1;
          r_shift <= {r_shift[15:0], i_rx_data};
          // Fourth byte completes the word; earlier bytes already sit MSB-first in r_shift.
          if (r_bcnt == 2'd3) begin
            r_we    <= 1'b1;
            r_addr  <= r_words[ADDR_WIDTH-1:0];
            r_wdata <= {r_shift, i_rx_data};
            r_words <= r_words + 16'd1;
            if (r_words + 16'd1 == r_n) r_state <= S_CHECK;
          end
        end
        S_CHECK: if (w_take) begin
          r_ready <= 1'b0;
          if (i_rx_data == r_acc) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_cpu_reset <= 1'b0;
          end else begin
            r_state <= S_ERROR;
            r_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rx_ready     = r_ready;
  assign o_imem_we      = r_we;
  assign o_imem_addr    = r_addr;
  assign o_imem_wdata   = r_wdata;
  assign o_cpu_reset    = r_cpu_reset;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_words_loaded = r_words;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader feeding the single-cycle MIPS core's instruction memory. It receives a byte stream over a valid/ready handshake, frames it as a header, payload and checksum, and assembles big-endian 32-bit instruction words. It writes those words to the instruction memory write port and holds the core in reset until the image has been loaded and verified. It sits directly upstream of the instruction memory and the core's PC/fetch path.

## Interface
- ADDR_WIDTH, 8, word-address width of instruction memory; depth = 2^ADDR_WIDTH words
- clock  in  1  rising-edge clock shared with the core
- reset  in  1  synchronous, active-high
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte
- imem_we  out  1  one-cycle write strobe to instruction memory
- imem_addr  out  ADDR_WIDTH  word address (PC >> 2)
- imem_wdata  out  32  assembled instruction word
- cpu_reset  out  1  drives the core's reset; high until load succeeds
- done  out  1  image loaded and checksum matched
- error  out  1  image rejected
- words_loaded  out  16  count of words written so far

## Operation
- Frame: 2-byte word count N (MSB first), then 4·N payload bytes, then 1 checksum byte = XOR of all payload bytes. Header bytes are not included in the checksum.
- A byte is accepted on a rising edge with rx_valid && rx_ready.
- States:
  - HDR_HI: accept byte, store N[15:8], go to HDR_LO.
  - HDR_LO: accept byte, store N[7:0].
    - If N > 2^ADDR_WIDTH, go to ERROR.
    - If N == 0, go to CHECK.
    - Otherwise go to DATA.
  - DATA: shift bytes in; the first byte of a word lands in bits [31:24]. On the 4th byte, issue a write, increment the word index, and XOR-accumulate every byte. After word N−1, go to CHECK.
  - CHECK: accept one byte. If it equals the accumulator, go to DONE; otherwise go to ERROR.
  - DONE and ERROR are terminal until reset.
- rx_ready = 1 in HDR_HI, HDR_LO, DATA and CHECK; 0 in DONE and ERROR. There is no other backpressure.
- Write: imem_we pulses for one cycle. In that cycle imem_addr = word index (0 to N−1) and imem_wdata = assembled word. imem_addr and imem_wdata hold their last values otherwise.
- words_loaded increments in the same cycle as each imem_we. It is 16-bit and cannot wrap, because N ≤ 2^ADDR_WIDTH ≤ 2^16 for ADDR_WIDTH ≤ 16.
- cpu_reset = 1 in every state except DONE. done = 1 only in DONE; error = 1 only in ERROR. done and error are never both high.
- Memory contents are never cleared by the loader.

## Timing
- Reset values (after the first clock edge with reset high): state HDR_HI, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, words_loaded=0, accumulator=0.
- Reset mid-frame: abandon the frame, return to reset values, and expect a new header next. Bytes presented during reset are ignored.
- Write latency: imem_we is high in the cycle immediately after the edge that accepted the 4th byte of a word.
- A byte accepted in the same cycle as an imem_we pulse is legal and must not be lost. Back-to-back valid bytes give one write every 4 cycles.
- HDR_LO to ERROR (N too large): error=1 and rx_ready=0 in the cycle after the edge that accepted the low header byte.
- CHECK to DONE: done=1 and cpu_reset=0 in the cycle after the edge that accepted the checksum byte. The last imem_we precedes this by at least one cycle, so the core never fetches before its final word is written.
- Gaps in rx_valid stall the FSM with no state change, and the partial word is held.
- rx_valid while in DONE or ERROR has no effect.

## Test plan
- Nominal load: reset, then 00 02, 20 08 00 05, 01 09 50 20, checksum 55 → imem_we at addr 0 with 0x20080005, then addr 1 with 0x01095020; words_loaded=2; done=1; cpu_reset=0; rx_ready=0.
- Bad checksum: same stream with checksum 54 → both writes occur, then error=1, done=0, cpu_reset stays 1, rx_ready=0.
- Empty image: 00 00, checksum 00 → no imem_we; done=1 one cycle after the checksum byte; words_loaded=0.
- Oversize image (ADDR_WIDTH=8): header 01 01 (257) → error=1 the cycle after the header, no writes, later bytes ignored. Header 01 00 (256) is accepted: last write lands at addr 255.
- Throttled source: nominal stream with rx_valid toggling every other cycle and a random 0–5 cycle gap mid-word → identical writes and final outputs to the nominal case.
- Reset mid-operation: assert reset after 6 payload bytes → all outputs return to reset values. Then resend the nominal stream → words_loaded counts from 0, addr 0/1 are written correctly, done=1.
